// File: rtl/puf_host_pkg.sv
// Shared types and pin map for the RO-PUF host-side controller.
package puf_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_RELEASE,
    ST_REPORT
  } state_e;

  localparam int CHAL_LSB  = 0;
  localparam int CHAL_W    = 6;
  localparam int START_BIT = 6;
  localparam int DONE_BIT  = 0;
  localparam int RESP_BIT  = 1;

  // Builds the tile's ui_in word; bit 7 is always driven low.
  function automatic logic [7:0] pin_word(input logic start, input logic [CHAL_W-1:0] chal);
    logic [7:0] w;
    w = '0;
    w[START_BIT] = start;
    w[CHAL_LSB +: CHAL_W] = chal;
    return w;
  endfunction

endpackage

// File: rtl/puf_sync2.sv
// Two-flop synchronizer for the asynchronous tile pins.
module puf_sync2 #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/puf_host_ctrl.sv
// Host initiator for the RO-PUF tile: sweeps RESP_BITS challenges over a
// four-phase start/done handshake and returns the packed response word.
module puf_host_ctrl
  import puf_host_pkg::*;
#(
  parameter int RESP_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [5:0]           req_seed,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 resp_err,
  output logic [7:0]           puf_ui_in,
  input  logic [7:0]           puf_uo_out
);

  localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0] pins_s;
  logic       done_s;
  logic       bit_s;
  logic       unused_pins;

  puf_sync2 #(.WIDTH(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({puf_uo_out[RESP_BIT], puf_uo_out[DONE_BIT]}),
    .q   (pins_s)
  );

  assign done_s      = pins_s[0];
  assign bit_s       = pins_s[1];
  assign unused_pins = ^puf_uo_out[7:2];

  state_e                state_q, state_d;
  logic [CHAL_W-1:0]     chal_q, chal_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [RESP_BITS-1:0]  data_q, data_d;
  logic                  err_q, err_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [7:0]            ui_q, ui_d;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    chal_d   = chal_q;
    idx_d    = idx_q;
    data_d   = data_q;
    err_d    = err_q;
    tmo_d    = tmo_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (req_valid) begin
          chal_d  = req_seed;
          data_d  = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (done_s) begin
          data_d[idx_q] = bit_s;
          tmo_d         = '0;
          state_d       = ST_RELEASE;
        end else if (tmo_q == TMO_MAX) begin
          err_d   = 1'b1;
          state_d = ST_REPORT;
        end
      end
      ST_RELEASE: begin
        if (!done_s) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_REPORT;
          end else begin
            idx_d   = idx_q + 1'b1;
            chal_d  = chal_q + 1'b1;
            tmo_d   = '0;
            state_d = ST_DRIVE;
          end
        end else if (tmo_q == TMO_MAX) begin
          err_d   = 1'b1;
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        tmo_d = '0;
        if (resp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet not a cycle late.
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_REPORT);
    unique case (state_d)
      ST_DRIVE:   ui_d = pin_word(1'b1, chal_d);
      ST_RELEASE: ui_d = pin_word(1'b0, chal_d);
      default:    ui_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      chal_q       <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      tmo_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      ui_q         <= '0;
    end else begin
      state_q      <= state_d;
      chal_q       <= chal_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      ui_q         <= ui_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = data_q;
  assign resp_err   = err_q;
  assign puf_ui_in  = ui_q;

endmodule

// File: tb/tb_puf_host_ctrl.sv
// Directed bench for puf_host_ctrl with a behavioral RO-PUF tile model.
module tb_puf_host_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_seed;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
  logic       resp_err;
  logic [7:0] puf_ui_in;
  logic [7:0] puf_uo_out;

  int vectors;
  int miscompares;

  puf_host_ctrl #(.RESP_BITS(8), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_seed   (req_seed),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .puf_ui_in  (puf_ui_in),
    .puf_uo_out (puf_uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tile model: done rises tile_d cycles after start, falls with start; bit = chal[0].
  int         tile_d;
  bit         tile_never;
  int         tile_stuck_at;
  logic       tile_done;
  logic       tile_bit;
  bit         tile_stuck;
  int         tile_cnt;
  int         tile_bits;
  logic [5:0] chal_log [0:63];

  assign puf_uo_out = {6'b0, tile_bit, tile_done};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_done  <= 1'b0;
      tile_bit   <= 1'b0;
      tile_stuck <= 1'b0;
      tile_cnt   <= 0;
      tile_bits  <= 0;
    end else if (!puf_ui_in[6]) begin
      tile_cnt <= 0;
      if (!tile_stuck) tile_done <= 1'b0;
    end else begin
      tile_cnt <= tile_cnt + 1;
      if (!tile_done && !tile_never && tile_cnt == tile_d - 1) begin
        tile_done <= 1'b1;
        tile_bit  <= puf_ui_in[0];
        chal_log[tile_bits] <= puf_ui_in[5:0];
        if (tile_bits == tile_stuck_at) tile_stuck <= 1'b1;
        tile_bits <= tile_bits + 1;
      end
    end
  end

  // Independent view of the synchronized done flag, used to flag start rising too early.
  logic ref_d1, ref_d2, prev_start;
  int   viol;
  always @(posedge clk) begin
    ref_d1 <= tile_done;
    ref_d2 <= ref_d1;
  end
  initial viol = 0;
  always @(negedge clk) begin
    prev_start <= puf_ui_in[6];
    if (puf_ui_in[6] && !prev_start && ref_d2) viol <= viol + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic issue_req(input logic [5:0] seed);
    req_seed  = seed;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (puf_ui_in !== {2'b01, seed}) begin
      miscompares++;
      $display("FAIL first_drive: puf_ui_in=%h expected %h", puf_ui_in, {2'b01, seed});
    end
  endtask

  task automatic wait_resp(input int budget);
    int n;
    n = 0;
    while (!resp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!resp_valid) begin
      miscompares++;
      $display("FAIL resp_timeout: resp_valid=%b after %0d cycles, expected 1", resp_valid, n);
    end
  endtask

  task automatic check_resp(input string name, input logic [7:0] exp_data, input logic exp_err);
    vectors++;
    if (resp_data !== exp_data || resp_err !== exp_err) begin
      miscompares++;
      $display("FAIL %s: data=%h err=%b expected data=%h err=%b", name, resp_data, resp_err, exp_data, exp_err);
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL handshake: req_ready=%b resp_valid=%b resp_err=%b expected 1 0 0", req_ready, resp_valid, resp_err);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (puf_ui_in !== 8'h00 || resp_valid !== 1'b0 || resp_data !== 8'h00 || resp_err !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_async: ui=%h rv=%b rd=%h re=%b rr=%b expected 00 0 00 0 1", puf_ui_in, resp_valid, resp_data, resp_err, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || puf_ui_in !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_release: rr=%b rv=%b ui=%h expected 1 0 00", req_ready, resp_valid, puf_ui_in);
    end
  endtask

  task automatic test_sweep_wrap();
    logic [5:0] exp_chal;
    int v0;
    tile_d = 5; tile_never = 1'b0; tile_stuck_at = -1;
    do_reset();
    v0 = viol;
    issue_req(6'h3E);
    wait_resp(400);
    check_resp("sweep_wrap", 8'hAA, 1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_chal = 6'h3E + 6'(i);
      vectors++;
      if (chal_log[i] !== exp_chal) begin
        miscompares++;
        $display("FAIL chal_order[%0d]: got %h expected %h", i, chal_log[i], exp_chal);
      end
    end
    vectors++;
    if (viol != v0) begin
      miscompares++;
      $display("FAIL start_overlap: %0d early start rises, expected 0", viol - v0);
    end
    finish_resp();
  endtask

  task automatic test_timeout_drive();
    tile_d = 5; tile_never = 1'b1; tile_stuck_at = -1;
    do_reset();
    issue_req(6'h05);
    wait_resp(40);
    check_resp("timeout_drive", 8'h00, 1'b1);
    vectors++;
    if (puf_ui_in !== 8'h00) begin
      miscompares++;
      $display("FAIL timeout_drive_pins: puf_ui_in=%h expected 00", puf_ui_in);
    end
    finish_resp();
    tile_never = 1'b0;
  endtask

  task automatic test_timeout_release();
    tile_d = 3; tile_never = 1'b0; tile_stuck_at = 2;
    do_reset();
    issue_req(6'h00);
    wait_resp(200);
    check_resp("timeout_release", 8'b0000_0010, 1'b1);
    vectors++;
    if (puf_ui_in !== 8'h00) begin
      miscompares++;
      $display("FAIL timeout_release_pins: puf_ui_in=%h expected 00", puf_ui_in);
    end
    finish_resp();
    tile_stuck_at = -1;
  endtask

  task automatic test_backpressure();
    tile_d = 1; tile_never = 1'b0; tile_stuck_at = -1;
    do_reset();
    issue_req(6'h11);
    wait_resp(300);
    check_resp("bp_initial", 8'h55, 1'b0);
    for (int i = 0; i < 10; i++) begin
      req_seed  = 6'h20;
      req_valid = (i == 3);
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b1 || resp_data !== 8'h55 || resp_err !== 1'b0 || req_ready !== 1'b0 || puf_ui_in !== 8'h00) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: rv=%b rd=%h re=%b rr=%b ui=%h expected 1 55 0 0 00",
                 i, resp_valid, resp_data, resp_err, req_ready, puf_ui_in);
      end
    end
    req_valid = 1'b0;
    finish_resp();
    for (int i = 0; i < 4; i++) @(negedge clk);
    vectors++;
    if (puf_ui_in !== 8'h00 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_no_queue: ui=%h rr=%b expected 00 1", puf_ui_in, req_ready);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    tile_d = 2; tile_never = 1'b0; tile_stuck_at = -1;
    do_reset();
    issue_req(6'h08);
    n = 0;
    while (!(tile_bits == 3 && puf_ui_in[6] && !tile_done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!(tile_bits == 3 && puf_ui_in[6])) begin
      miscompares++;
      $display("FAIL reach_bit3: bits=%0d start=%b expected 3 1", tile_bits, puf_ui_in[6]);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (puf_ui_in !== 8'h00 || resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid: ui=%h rv=%b rr=%b rd=%h expected 00 0 1 00", puf_ui_in, resp_valid, req_ready, resp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue_req(6'h11);
    wait_resp(300);
    check_resp("after_reset", 8'h55, 1'b0);
    finish_resp();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_seed      = '0;
    resp_ready    = 1'b0;
    tile_d        = 5;
    tile_never    = 1'b0;
    tile_stuck_at = -1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    test_reset();
    test_sweep_wrap();
    test_timeout_drive();
    test_timeout_release();
    test_backpressure();
    test_reset_mid_sweep();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
